// File: rtl/peripheral_biu_verilog_pkg.sv
// Shared definitions for the BIU arbiter: AHB HBURST codes, FSM states and
// the burst-type to beat-count mapping.
package peripheral_biu_verilog_pkg;

    localparam logic [2:0] SINGLE = 3'd0;
    localparam logic [2:0] INCR   = 3'd1;
    localparam logic [2:0] WRAP4  = 3'd2;
    localparam logic [2:0] INCR4  = 3'd3;
    localparam logic [2:0] WRAP8  = 3'd4;
    localparam logic [2:0] INCR8  = 3'd5;
    localparam logic [2:0] WRAP16 = 3'd6;
    localparam logic [2:0] INCR16 = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } biu_arb_state_e;

    // Returns beats-1 so the counter can terminate on zero.
    function automatic logic [3:0] burst_beats_m1(input logic [2:0] hburst);
        logic [3:0] cnt;
        case (hburst)
            SINGLE, INCR:   cnt = 4'd0;
            WRAP4,  INCR4:  cnt = 4'd3;
            WRAP8,  INCR8:  cnt = 4'd7;
            default:        cnt = 4'd15;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/pu_riscv_rr_picker.sv
// Combinational round-robin picker: selects the first requester above 'last',
// wrapping to the lowest requester when none lies above it.
module pu_riscv_rr_picker #(
    parameter int PORTS = 2
) (
    input  logic [PORTS-1:0]         req,
    input  logic [$clog2(PORTS)-1:0] last,
    output logic [PORTS-1:0]         onehot,
    output logic [$clog2(PORTS)-1:0] idx
);

    localparam int SW = $clog2(PORTS);

    logic [PORTS-1:0]          above;
    logic [PORTS-1:0]          masked;
    logic [PORTS-1:0]          cand_vec;
    logic [SW-1:0][PORTS-1:0]  bit_mask;

    for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
        assign above[gi] = (SW'(gi) > last);
        for (genvar bj = 0; bj < SW; bj++) begin : g_bit
            assign bit_mask[bj][gi] = 1'((gi >> bj) & 1);
        end
    end

    assign masked   = req & above;
    assign cand_vec = (|masked) ? masked : req;
    // Isolate the lowest set bit of the candidate vector.
    assign onehot   = cand_vec & (~cand_vec + PORTS'(1));

    for (genvar bj = 0; bj < SW; bj++) begin : g_idx
        assign idx[bj] = |(onehot & bit_mask[bj]);
    end

endmodule

// File: rtl/pu_riscv_biu_arbiter.sv
// Round-robin arbiter sharing one BIU among PORTS requesters, with burst
// beat counting, lock retention and error abort.
module pu_riscv_biu_arbiter
    import peripheral_biu_verilog_pkg::*;
#(
    parameter int PORTS = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [PORTS-1:0]         req_i,
    input  logic [PORTS-1:0][2:0]    type_i,
    input  logic [PORTS-1:0]         lock_i,
    output logic [PORTS-1:0]         req_ack_o,
    output logic [PORTS-1:0]         ack_o,
    output logic [PORTS-1:0]         err_o,
    output logic [PORTS-1:0]         gnt_o,
    output logic [$clog2(PORTS)-1:0] sel_o,
    output logic                     busy_o,
    output logic                     biu_req_o,
    input  logic                     biu_req_ack_i,
    input  logic                     biu_ack_i,
    input  logic                     biu_err_i
);

    localparam int SW = $clog2(PORTS);

    biu_arb_state_e   state_reg, state_next;
    logic [PORTS-1:0] gnt_reg, gnt_next;
    logic [SW-1:0]    sel_reg, sel_next;
    logic [SW-1:0]    last_reg, last_next;
    logic [3:0]       beat_cnt_reg, beat_cnt_next;

    logic [PORTS-1:0] pick_oh;
    logic [SW-1:0]    pick_idx;

    pu_riscv_rr_picker #(
        .PORTS (PORTS)
    ) u_picker (
        .req    (req_i),
        .last   (last_reg),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            gnt_reg      <= '0;
            sel_reg      <= '0;
            last_reg     <= SW'(PORTS - 1);
            beat_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            sel_reg      <= sel_next;
            last_reg     <= last_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        sel_next      = sel_reg;
        last_next     = last_reg;
        beat_cnt_next = beat_cnt_reg;
        req_ack_o     = '0;
        ack_o         = '0;
        err_o         = '0;
        biu_req_o     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (|req_i) begin
                    gnt_next   = pick_oh;
                    sel_next   = pick_idx;
                    state_next = ADDR;
                end
            end

            ADDR: begin
                biu_req_o = 1'b1;
                if (biu_err_i) begin
                    err_o      = gnt_reg;
                    last_next  = sel_reg;
                    gnt_next   = '0;
                    sel_next   = '0;
                    state_next = IDLE;
                end else if (biu_req_ack_i) begin
                    req_ack_o     = gnt_reg;
                    beat_cnt_next = burst_beats_m1(type_i[sel_reg]);
                    state_next    = DATA;
                end
            end

            DATA: begin
                if (biu_ack_i) begin
                    ack_o = gnt_reg;
                end
                // An error always terminates the burst; lock is not honoured.
                if (biu_err_i) begin
                    err_o      = gnt_reg;
                    last_next  = sel_reg;
                    gnt_next   = '0;
                    sel_next   = '0;
                    state_next = IDLE;
                end else if (biu_ack_i) begin
                    if (beat_cnt_reg == 4'd0) begin
                        if (lock_i[sel_reg] && req_i[sel_reg]) begin
                            state_next = ADDR;
                        end else begin
                            last_next  = sel_reg;
                            gnt_next   = '0;
                            sel_next   = '0;
                            state_next = IDLE;
                        end
                    end else begin
                        beat_cnt_next = beat_cnt_reg - 4'd1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                gnt_next   = '0;
                sel_next   = '0;
            end
        endcase
    end

    assign gnt_o  = gnt_reg;
    assign sel_o  = sel_reg;
    assign busy_o = (state_reg != IDLE);

endmodule

// File: tb/tb_pu_riscv_biu_arbiter.sv
// Self-checking bench for pu_riscv_biu_arbiter: the bench plays the BIU and
// the requesters, predicting grants with a round-robin model.
module tb_pu_riscv_biu_arbiter;

    localparam int PORTS = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req;
    logic [1:0][2:0]  typ;
    logic [1:0]       lock;
    logic             biu_req_ack, biu_ack, biu_err;
    logic [1:0]       req_ack, ack, err, gnt;
    logic             sel;
    logic             busy, biu_req;

    int tests = 0;
    int fails = 0;
    int last_m = PORTS - 1;

    always #5 clk = ~clk;

    pu_riscv_biu_arbiter #(
        .PORTS (PORTS)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req),
        .type_i        (typ),
        .lock_i        (lock),
        .req_ack_o     (req_ack),
        .ack_o         (ack),
        .err_o         (err),
        .gnt_o         (gnt),
        .sel_o         (sel),
        .busy_o        (busy),
        .biu_req_o     (biu_req),
        .biu_req_ack_i (biu_req_ack),
        .biu_ack_i     (biu_ack),
        .biu_err_i     (biu_err)
    );

    // Number of beats for an HBURST code: 0/1 -> 1, then 4, 8, 16 per pair.
    function automatic int beats_of(input logic [2:0] t);
        int ti;
        ti = int'(t);
        return (ti < 2) ? 1 : (2 << (ti / 2));
    endfunction

    function automatic int rr_pick(input logic [1:0] r);
        for (int k = 1; k <= PORTS; k++) begin
            int p;
            p = (last_m + k) % PORTS;
            if (r[p]) return p;
        end
        return -1;
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req = '0; lock = '0;
        biu_req_ack = 1'b0; biu_ack = 1'b0; biu_err = 1'b0;
        repeat (2) tick;
        rst_n = 1'b1;
        last_m = PORTS - 1;
    endtask

    // Entered during the first ADDR cycle of a burst for port p (before
    // sampling); returns 1ns after the negedge following the burst end.
    task automatic biu_burst(input string name, input int p, input int nbeats,
                             input int ack_dly, input int gap, input int err_beat);
        logic [1:0] oh;
        int  n_ack, exp_acks;
        bit  ended, locked_next, err_now;
        oh = 2'b01 << p;
        n_ack = 0; ended = 0; locked_next = 0;
        #1;
        tests++;
        if (gnt !== oh || sel !== 1'(p) || biu_req !== 1'b1 || busy !== 1'b1 || ack !== 2'b00) begin
            fails++;
            $display("FAIL %s addr_entry: gnt=%b sel=%b biu_req=%b busy=%b ack=%b, want gnt=%b sel=%0d biu_req=1 busy=1 ack=00",
                     name, gnt, sel, biu_req, busy, ack, oh, p);
        end
        biu_ack = 1'b0;
        for (int d = 0; d < ack_dly; d++) begin
            #1;
            tests++;
            if (req_ack !== 2'b00 || biu_req !== 1'b1) begin
                fails++;
                $display("FAIL %s addr_wait: req_ack=%b biu_req=%b, want 00/1", name, req_ack, biu_req);
            end
            tick;
        end
        biu_req_ack = 1'b1;
        #1;
        tests++;
        if (req_ack !== oh) begin
            fails++;
            $display("FAIL %s req_ack: got %b want %b", name, req_ack, oh);
        end
        tick;
        biu_req_ack = 1'b0;
        for (int b = 0; b < nbeats && !ended; b++) begin
            for (int g = 0; g < gap; g++) begin
                #1;
                tests++;
                if (ack !== 2'b00 || err !== 2'b00 || busy !== 1'b1 || gnt !== oh) begin
                    fails++;
                    $display("FAIL %s data_gap: ack=%b err=%b busy=%b gnt=%b, want 00/00/1/%b",
                             name, ack, err, busy, gnt, oh);
                end
                tick;
            end
            err_now = (b == err_beat);
            biu_ack = 1'b1;
            biu_err = err_now;
            #1;
            tests++;
            if (ack !== oh) begin
                fails++;
                $display("FAIL %s beat%0d_ack: got %b want %b", name, b, ack, oh);
            end
            if (ack === oh) n_ack++;
            tests++;
            if (err !== (err_now ? oh : 2'b00)) begin
                fails++;
                $display("FAIL %s beat%0d_err: got %b want %b", name, b, err, err_now ? oh : 2'b00);
            end
            ended = err_now || (b == nbeats - 1);
            locked_next = !err_now && ended && lock[p] && req[p];
            tick;
            biu_ack = 1'b0;
            biu_err = 1'b0;
        end
        #1;
        exp_acks = (err_beat >= 0 && err_beat < nbeats) ? err_beat + 1 : nbeats;
        tests++;
        if (n_ack != exp_acks) begin
            fails++;
            $display("FAIL %s ack_count: got %0d want %0d", name, n_ack, exp_acks);
        end
        tests++;
        if (locked_next) begin
            if (busy !== 1'b1 || biu_req !== 1'b1 || gnt !== oh) begin
                fails++;
                $display("FAIL %s locked_regrant: busy=%b biu_req=%b gnt=%b, want 1/1/%b",
                         name, busy, biu_req, gnt, oh);
            end
        end else begin
            if (busy !== 1'b0 || biu_req !== 1'b0 || gnt !== 2'b00) begin
                fails++;
                $display("FAIL %s end_idle: busy=%b biu_req=%b gnt=%b, want 0/0/00",
                         name, busy, biu_req, gnt);
            end
            last_m = p;
        end
        $display("[TB] burst %s port=%0d beats=%0d acks=%0d err_beat=%0d locked=%0d",
                 name, p, nbeats, n_ack, err_beat, locked_next);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req = 2'b11; lock = 2'b11; typ = '0;
        biu_req_ack = 1'b1; biu_ack = 1'b1; biu_err = 1'b1;
        tick;
        #1;
        tests++;
        if (gnt !== 2'b00 || sel !== 1'b0 || busy !== 1'b0 || biu_req !== 1'b0 ||
            req_ack !== 2'b00 || ack !== 2'b00 || err !== 2'b00) begin
            fails++;
            $display("FAIL reset_outputs: gnt=%b sel=%b busy=%b biu_req=%b req_ack=%b ack=%b err=%b, want all 0",
                     gnt, sel, busy, biu_req, req_ack, ack, err);
        end
        tick;
        req = 2'b00; lock = 2'b00;
        biu_req_ack = 1'b0; biu_ack = 1'b0; biu_err = 1'b0;
        rst_n = 1'b1;
        last_m = PORTS - 1;
        repeat (3) tick;
        #1;
        tests++;
        if (busy !== 1'b0 || gnt !== 2'b00) begin
            fails++;
            $display("FAIL reset_idle_no_req: busy=%b gnt=%b, want 0/00", busy, gnt);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_round_robin;
        req = 2'b11;
        typ = '0;
        for (int i = 0; i < 4; i++) begin
            tick;
            biu_burst("rr", i % 2, 1, $urandom_range(0, 2), 0, -1);
        end
        req = 2'b00;
    endtask

    task automatic test_incr8;
        req = 2'b10;
        typ[1] = 3'd5;
        typ[0] = 3'd0;
        tick;
        biu_burst("incr8", 1, beats_of(typ[1]), 2, 1, -1);
        req = 2'b00;
    endtask

    task automatic test_lock;
        do_reset;
        req = 2'b11;
        lock = 2'b01;
        typ[0] = 3'd2;
        typ[1] = 3'd0;
        tick;
        biu_burst("lock1", 0, beats_of(typ[0]), 0, 0, -1);
        biu_burst("lock2", 0, beats_of(typ[0]), 1, 0, -1);
        lock = 2'b00;
        biu_burst("lock3", 0, beats_of(typ[0]), 0, 1, -1);
        tick;
        biu_burst("after_lock", rr_pick(req), beats_of(typ[1]), 0, 0, -1);
        req = 2'b00;
    endtask

    task automatic test_error;
        int p;
        req = 2'b11;
        typ[0] = 3'd7;
        typ[1] = 3'd7;
        lock = 2'b11;
        p = rr_pick(req);
        tick;
        biu_burst("err16", p, beats_of(typ[p]), 1, 0, 4);
        p = rr_pick(req);
        typ[p] = 3'd0;
        tick;
        biu_burst("after_err", p, beats_of(typ[p]), 0, 0, -1);
        lock = 2'b00;
        req = 2'b00;
    endtask

    task automatic test_reset_mid;
        do_reset;
        req = 2'b01;
        typ[0] = 3'd5;
        typ[1] = 3'd0;
        tick;
        #1;
        tests++;
        if (gnt !== 2'b01 || biu_req !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_grant: gnt=%b biu_req=%b, want 01/1", gnt, biu_req);
        end
        biu_req_ack = 1'b1;
        tick;
        biu_req_ack = 1'b0;
        biu_ack = 1'b1;
        tick;
        req = 2'b11;
        #1;
        tests++;
        if (ack !== 2'b01 || busy !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_data: ack=%b busy=%b, want 01/1", ack, busy);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (gnt !== 2'b00 || sel !== 1'b0 || busy !== 1'b0 || biu_req !== 1'b0 ||
            req_ack !== 2'b00 || ack !== 2'b00 || err !== 2'b00) begin
            fails++;
            $display("FAIL rstmid_outputs: gnt=%b sel=%b busy=%b biu_req=%b req_ack=%b ack=%b err=%b, want all 0",
                     gnt, sel, busy, biu_req, req_ack, ack, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        biu_ack = 1'b0;
        req = 2'b10;
        last_m = PORTS - 1;
        #1;
        tests++;
        if (gnt !== 2'b00 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_release: gnt=%b busy=%b, want 00/0", gnt, busy);
        end
        tick;
        biu_burst("post_reset", rr_pick(req), beats_of(typ[1]), 0, 0, -1);
        req = 2'b00;
    endtask

    task automatic test_random;
        int p, nb, eb;
        lock = 2'b00;
        for (int i = 0; i < 25; i++) begin
            req = 2'($urandom_range(1, 3));
            typ[0] = 3'($urandom_range(0, 7));
            typ[1] = 3'($urandom_range(0, 7));
            biu_ack = 1'($urandom_range(0, 1));
            #1;
            tests++;
            if (ack !== 2'b00 || err !== 2'b00 || busy !== 1'b0) begin
                fails++;
                $display("FAIL rand%0d_idle: ack=%b err=%b busy=%b, want 00/00/0", i, ack, err, busy);
            end
            p = rr_pick(req);
            nb = beats_of(typ[p]);
            eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
            tick;
            biu_burst("rand", p, nb, $urandom_range(0, 3), $urandom_range(0, 2), eb);
        end
        req = 2'b00;
        biu_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0; typ = '0; lock = '0;
        biu_req_ack = 1'b0; biu_ack = 1'b0; biu_err = 1'b0;
        test_reset;
        test_round_robin;
        test_incr8;
        test_lock;
        test_error;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pu_riscv_biu_arbiter.md
PU_RISCV_BIU_ARBITER -- requirements
Module: pu_riscv_biu_arbiter

Interface
REQ-001 Parameter PORTS, default 2: number of requesters; SHALL support 2..8.
REQ-002 clk_i  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rst_ni  input  1  reset; asynchronous, active-low.
REQ-004 req_i  input  PORTS  per-port access request, held until req_ack_o[p].
REQ-005 type_i  input  PORTS x 3  per-port burst type, AHB HBURST encoding.
REQ-006 lock_i  input  PORTS  per-port lock; retains the grant across bursts.
REQ-007 req_ack_o  output  PORTS  per-port request acknowledge.
REQ-008 ack_o  output  PORTS  per-port data acknowledge.
REQ-009 err_o  output  PORTS  per-port error.
REQ-010 gnt_o  output  PORTS  one-hot grant, steers the downstream mux.
REQ-011 sel_o  output  clog2(PORTS)  binary index of the granted port.
REQ-012 busy_o  output  1  high in any state other than IDLE.
REQ-013 biu_req_o  output  1  request to BIU.
REQ-014 biu_req_ack_i  input  1  BIU request acknowledge.
REQ-015 biu_ack_i  input  1  BIU beat acknowledge.
REQ-016 biu_err_i  input  1  BIU error, which terminates the transfer.

Function
REQ-017 FSM states SHALL be IDLE, ADDR and DATA.
REQ-018 IDLE: if any req_i is high, the FSM SHALL register the winner into gnt_o/sel_o and go to ADDR next cycle; otherwise gnt_o SHALL be 0.
REQ-019 Arbitration SHALL be round-robin: the winner is the first requesting port after last_q, searching upward and wrapping from PORTS-1 to 0.
REQ-020 ADDR: biu_req_o SHALL be 1; on biu_req_ack_i, req_ack_o[sel] SHALL pulse for that cycle and the FSM SHALL go to DATA.
REQ-021 On entry to DATA, beat_cnt SHALL load beats-1 of type_i[sel]: SINGLE/INCR (0,1) give 0, WRAP4/INCR4 (2,3) give 3, WRAP8/INCR8 (4,5) give 7, WRAP16/INCR16 (6,7) give 15; beat_cnt is 4 bits.
REQ-022 DATA: each biu_ack_i SHALL drive ack_o[sel]=1 in the same cycle (combinational) and decrement beat_cnt.
REQ-023 DATA with biu_ack_i and beat_cnt==0 SHALL end the burst: last_q<=sel, and the FSM SHALL go to IDLE.
REQ-024 Lock: at burst end, if lock_i[sel] and req_i[sel] are both high, the FSM SHALL go directly to ADDR with the same grant, and last_q SHALL NOT update.
REQ-025 biu_err_i in ADDR or DATA SHALL drive err_o[sel]=1 combinationally, abort the burst regardless of beat_cnt, update last_q, and go to IDLE; lock SHALL be ignored on error.
REQ-026 biu_ack_i and biu_err_i in the same cycle: the error SHALL take precedence, and ack_o SHALL still pulse.
REQ-027 gnt_o/sel_o SHALL remain stable from ADDR entry until return to IDLE; req_i changes mid-burst SHALL have no effect.
REQ-028 req_ack_o, ack_o and err_o SHALL be 0 for every non-granted port and in IDLE.
REQ-029 biu_ack_i or biu_err_i in IDLE SHALL be ignored.
REQ-030 Grant latency: a request in idle cycle N SHALL see gnt_o and biu_req_o in cycle N+1; the minimum gap between consecutive unlocked bursts is one IDLE cycle.

Reset
REQ-031 Asserting rst_ni SHALL force state=IDLE, beat_cnt=0, last_q=PORTS-1 (port 0 wins first), gnt_o=0, sel_o=0 and every output=0, immediately and mid-burst included.
REQ-032 After deassertion, the first arbitration SHALL occur on the first rising edge with req_i nonzero.

Structure
REQ-033 Burst-type constants (SINGLE..INCR16) and the state enum SHALL reside in peripheral_biu_verilog_pkg; the type-to-count function SHALL be a package function.
REQ-034 The round-robin priority picker SHALL be a sub-module pu_riscv_rr_picker (inputs req and last; output one-hot and index), purely combinational.

Verification
REQ-035 PORTS=2, req_i=2'b11 from reset, SINGLE -> port 0 granted first, then port 1, then port 0; each wins alternately.
REQ-036 Port 1 INCR8, req_ack after 2 cycles, 8 acks with 1-cycle gaps -> exactly 8 ack_o[1] pulses, then IDLE; ack_o[0] stays 0 throughout.
REQ-037 Port 0 WRAP4 with lock_i[0]=1 and req_i=2'b11 -> 3 back-to-back port-0 bursts while locked with no IDLE between them; port 1 is granted the cycle after lock drops.
REQ-038 INCR16 with biu_err_i on beat 5 -> err_o pulses once, FSM returns to IDLE, and the next grant goes to the other port.
REQ-039 rst_ni asserted in DATA with beat_cnt=6 -> all outputs 0 at once; after release, req_i=2'b10 is granted to port 1 one cycle later.
